// File: rtl/lt_arbiter.sv
// lt_arbiter: two requesters share one WIDTH-bit less-than unit.
// Define LT_UNSIGNED_EN to add per-request unsigned-compare inputs.
module lt_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
`ifdef LT_UNSIGNED_EN
  input  logic             req0_uns,
  input  logic             req1_uns,
`endif
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [31:0]      resp_lt,
  input  logic             resp_ready,
  output logic [15:0]      done_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic             gnt;
  logic             idle_ok;
  logic             hs;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             lt_bit;
  logic             sgn_lt;

`ifdef LT_UNSIGNED_EN
  logic             op_uns;
  logic [WIDTH:0]   diff;
`else
  logic [WIDTH-1:0] diff;
`endif

  // Round-robin pick: a tie goes to whoever did not win last time.
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      req0_valid && req1_valid: gnt = ~last_grant;
      !req0_valid && req1_valid: gnt = 1'b1;
      default: gnt = 1'b0;
    endcase
  end

  assign idle_ok    = rst_n && (state == IDLE);
  assign req0_ready = idle_ok && req0_valid && !gnt;
  assign req1_ready = idle_ok && req1_valid && gnt;
  assign hs         = req0_ready || req1_ready;
  assign resp_valid = (state == RESP);

  // Shared compare: sign bits decide when they differ, else the sign
  // of the difference; the extra borrow bit gives the unsigned result.
  always_comb begin
`ifdef LT_UNSIGNED_EN
    diff = {1'b0, op_a} - {1'b0, op_b};
`else
    diff = op_a - op_b;
`endif
    if (op_a[WIDTH-1] != op_b[WIDTH-1])
      sgn_lt = op_a[WIDTH-1];
    else
      sgn_lt = diff[WIDTH-1];
`ifdef LT_UNSIGNED_EN
    lt_bit = op_uns ? diff[WIDTH] : sgn_lt;
`else
    lt_bit = sgn_lt;
`endif
  end

  // Next-state sequencing IDLE -> CMP -> RESP -> IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (hs) state_nx = CMP;
      CMP:  state_nx = RESP;
      RESP: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operand capture, result register and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
`ifdef LT_UNSIGNED_EN
      op_uns     <= 1'b0;
`endif
      resp_id    <= 1'b0;
      resp_lt    <= 32'h0;
      last_grant <= 1'b1;
      done_cnt   <= 16'h0;
    end else begin
      if (hs) begin
        op_a       <= gnt ? req1_a : req0_a;
        op_b       <= gnt ? req1_b : req0_b;
`ifdef LT_UNSIGNED_EN
        op_uns     <= gnt ? req1_uns : req0_uns;
`endif
        resp_id    <= gnt;
        last_grant <= gnt;
      end
      if (state == CMP)
        resp_lt <= {31'h0, lt_bit};
      if (state == RESP && resp_ready)
        done_cnt <= done_cnt + 16'h1;
    end
  end

endmodule

// File: tb/tb_lt_arbiter.sv
// tb_lt_arbiter: randomized and directed checks of lt_arbiter
// against a transaction-level reference model.
module tb_lt_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_uns, req1_uns;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_id, resp_ready;
  logic [31:0] resp_lt;
  logic [15:0] done_cnt;

  int total = 0;
  int bad   = 0;

  logic m_last;
  int   m_done;

  always #5 clk = ~clk;

  lt_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
`ifdef LT_UNSIGNED_EN
    .req0_uns   (req0_uns),
    .req1_uns   (req1_uns),
`endif
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_lt    (resp_lt),
    .resp_ready (resp_ready),
    .done_cnt   (done_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_lt(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic u);
    logic r;
`ifdef LT_UNSIGNED_EN
    if (u) r = (a < b);
    else   r = ($signed(a) < $signed(b));
`else
    r = ($signed(a) < $signed(b)) ^ (u & 1'b0);
`endif
    return {31'h0, r};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'h80000000;
      2: v = 32'h7FFFFFFF;
      3: v = 32'hFFFFFFFF;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // One full transaction, entered and left at posedge+1 in IDLE.
  task automatic run_txn(input logic v0, input logic v1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input logic u0, input logic u1,
                         input int stall);
    logic        g;
    logic [31:0] e_lt;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_uns = u0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_uns = u1;
    resp_ready = 1'b0;
    #1;
    g = (v0 && v1) ? !m_last : v1;
    chk("ready0", {31'h0, req0_ready}, {31'h0, v0 && !g});
    chk("ready1", {31'h0, req1_ready}, {31'h0, v1 && g});
    e_lt = g ? ref_lt(a1, b1, u1) : ref_lt(a0, b0, u0);
    m_last = g;
    @(posedge clk); #1;
    chk("cmp_valid", {31'h0, resp_valid}, 32'h0);
    chk("cmp_ready", {31'h0, req0_ready | req1_ready}, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) resp_ready = 1'b1;
      chk("resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("resp_id", {31'h0, resp_id}, {31'h0, g});
      chk("resp_lt", resp_lt, e_lt);
      chk("resp_ready0", {31'h0, req0_ready | req1_ready}, 32'h0);
      chk("hold_cnt", {16'h0, done_cnt}, m_done[31:0] & 32'hFFFF);
      @(posedge clk); #1;
    end
    m_done++;
    resp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("done_cnt", {16'h0, done_cnt}, m_done[31:0] & 32'hFFFF);
    chk("back_idle", {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        v0, v1;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_uns = 0; req1_uns = 0;
    resp_ready = 1'b1;
    m_last = 1'b1;
    m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {30'h0, req0_ready, req1_ready}, 32'h0);
    chk("rst_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_id", {31'h0, resp_id}, 32'h0);
    chk("rst_lt", resp_lt, 32'h0);
    chk("rst_cnt", {16'h0, done_cnt}, 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(1, 0, 32'd5, 32'd9, 0, 0, 0, 0, 0);
    run_txn(1, 0, 32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 0, 0);
    run_txn(0, 1, 0, 0, 32'h7FFFFFFF, 32'h80000000, 0, 0, 0);
    run_txn(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 1);

    for (int i = 0; i < 4; i++)
      run_txn(1, 1, pick(), pick(), pick(), pick(), 0, 0, 0);

    run_txn(1, 1, 32'd3, 32'd2, 32'hFFFFFFFE, 32'd1, 0, 0, 5);

    // reset while the compare is in flight
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd1; req0_b = 32'd2; req1_a = 32'd1; req1_b = 32'd2;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("cmp_rst_ready", {30'h0, req0_ready, req1_ready}, 32'h0);
    chk("cmp_rst_valid", {31'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    chk("cmp_rst_valid2", {31'h0, resp_valid}, 32'h0);
    chk("cmp_rst_cnt", {16'h0, done_cnt}, 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    m_last = 1'b1;
    m_done = 0;
    @(posedge clk); #1;
    run_txn(1, 1, 32'd7, 32'd7, 32'd0, 32'd1, 0, 0, 0);

`ifdef LT_UNSIGNED_EN
    run_txn(1, 0, 32'h80000000, 32'd1, 0, 0, 1, 0, 0);
    run_txn(1, 0, 32'h80000000, 32'd1, 0, 0, 0, 0, 0);
    run_txn(0, 1, 0, 0, 32'h80000000, 32'd1, 0, 1, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) begin
        resp_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        chk("idle_ready", {30'h0, req0_ready, req1_ready}, 32'h0);
        chk("idle_cnt", {16'h0, done_cnt}, m_done[31:0] & 32'hFFFF);
        chk("idle_valid", {31'h0, resp_valid}, 32'h0);
        resp_ready = 1'b0;
      end else begin
        a = pick();
        b = ($urandom_range(0, 4) == 0) ? a : pick();
        run_txn(v0, v1, a, b, pick(), pick(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
